// File: rtl/tamagotchi_status_display.sv
// Drives a 4-digit multiplexed active-low 7-segment display from the pet FSM codes:
// stat letter, face glyph and a blinking two-digit level, re-latched once per scan frame.
module tamagotchi_status_display #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_DIV   = 12500000,
    parameter int BLINK_LEVEL = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] display_out,
    input  logic [1:0] display_out2,
    input  logic [3:0] nivel,
    output logic [6:0] seg_display,
    output logic [3:0] an
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    // Out-of-range levels (11..15) must never blink, so the threshold is capped at 10.
    localparam logic [3:0] BLINK_MAX = (BLINK_LEVEL > 10) ? 4'd10 : 4'(BLINK_LEVEL);

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_S     = 7'b0010010;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_H     = 7'b0001001;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_U     = 7'b1000001;
    localparam logic [6:0] GLYPH_N     = 7'b0101011;
    localparam logic [6:0] GLYPH_Z     = 7'b0100100;
    localparam logic [6:0] GLYPH_ONE   = 7'b1111001;
    localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;

    function automatic logic [6:0] digit_glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [1:0]         lat_stat;
    logic               lat_happy;
    logic               lat_neutral;
    logic               lat_sleep;
    logic [3:0]         lat_level;

    logic       scan_wrap;
    logic       blink_wrap;
    logic       frame_end;
    logic       level_hidden;
    logic [6:0] glyph;
    logic [6:0] seg_next;
    logic [3:0] an_next;

    always_comb begin
        scan_wrap    = (scan_cnt == SCAN_LAST);
        blink_wrap   = (blink_cnt == BLINK_LAST);
        frame_end    = scan_wrap && (digit == 2'd3);
        level_hidden = blink_phase && !lat_sleep && (lat_level <= BLINK_MAX);
        glyph        = GLYPH_BLANK;

        case (digit)
            2'd3: begin
                case (lat_stat)
                    2'b00:   glyph = GLYPH_S;
                    2'b01:   glyph = GLYPH_E;
                    2'b10:   glyph = GLYPH_H;
                    default: glyph = GLYPH_D;
                endcase
            end
            2'd2: begin
                if (lat_sleep)        glyph = GLYPH_Z;
                else if (lat_neutral) glyph = GLYPH_DASH;
                else if (lat_happy)   glyph = GLYPH_U;
                else                  glyph = GLYPH_N;
            end
            2'd1: begin
                if (lat_level > 4'd10)       glyph = GLYPH_DASH;
                else if (lat_level == 4'd10) glyph = GLYPH_ONE;
                else                         glyph = GLYPH_BLANK;
            end
            default: begin
                if (lat_level > 4'd10)       glyph = GLYPH_DASH;
                else if (lat_level == 4'd10) glyph = GLYPH_ZERO;
                else                         glyph = digit_glyph(lat_level);
            end
        endcase

        if (!digit[1] && level_hidden) glyph = GLYPH_BLANK;

        // The first clock of every slot is blanked so the previous digit cannot ghost.
        an_next  = ~(4'b0001 << digit);
        seg_next = glyph;
        if (scan_cnt == '0) begin
            an_next  = 4'b1111;
            seg_next = GLYPH_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            digit    <= 2'd0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Inputs are captured only at the frame boundary so a frame never mixes old and new values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_stat    <= 2'b00;
            lat_happy   <= 1'b0;
            lat_neutral <= 1'b1;
            lat_sleep   <= 1'b0;
            lat_level   <= 4'd0;
        end else if (frame_end) begin
            lat_stat    <= display_out[1:0];
            lat_happy   <= display_out[2];
            lat_neutral <= display_out[3];
            lat_sleep   <= (display_out2 == 2'b01);
            lat_level   <= nivel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an          <= 4'b1111;
            seg_display <= GLYPH_BLANK;
        end else begin
            an          <= an_next;
            seg_display <= seg_next;
        end
    end

endmodule

// File: tb/tb_tamagotchi_status_display.sv
// Self-checking bench for tamagotchi_status_display: directed frame vectors, latch timing,
// blink behaviour around the threshold and asynchronous reset in the middle of a slot.
module tb_tamagotchi_status_display;

    localparam int SCAN_DIV    = 4;
    localparam int BLINK_DIV   = 64;
    localparam int BLINK_LEVEL = 2;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] L_S   = 7'b0010010;
    localparam logic [6:0] L_E   = 7'b0000110;
    localparam logic [6:0] L_H   = 7'b0001001;
    localparam logic [6:0] L_D   = 7'b0100001;
    localparam logic [6:0] F_U   = 7'b1000001;
    localparam logic [6:0] F_N   = 7'b0101011;
    localparam logic [6:0] F_Z   = 7'b0100100;
    localparam logic [6:0] G0    = 7'b1000000;
    localparam logic [6:0] G1    = 7'b1111001;
    localparam logic [6:0] G2    = 7'b0100100;
    localparam logic [6:0] G3    = 7'b0110000;
    localparam logic [6:0] G4    = 7'b0011001;
    localparam logic [6:0] G5    = 7'b0010010;
    localparam logic [6:0] G6    = 7'b0000010;
    localparam logic [6:0] G7    = 7'b1111000;
    localparam logic [6:0] G8    = 7'b0000000;
    localparam logic [6:0] G9    = 7'b0010000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] display_out;
    logic [1:0] display_out2;
    logic [3:0] nivel;
    logic [6:0] seg_display;
    logic [3:0] an;

    int errors = 0;
    int checks = 0;

    tamagotchi_status_display #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_DIV   (BLINK_DIV),
        .BLINK_LEVEL (BLINK_LEVEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .display_out  (display_out),
        .display_out2 (display_out2),
        .nivel        (nivel),
        .seg_display  (seg_display),
        .an           (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dout;
        logic [1:0] dout2;
        logic [3:0] lvl;
        logic [6:0] e3;
        logic [6:0] e2;
        logic [6:0] e1;
        logic [6:0] e0;
    } vec_t;

    vec_t vecs[12];

    task automatic check7(input string name, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Digit strobes must come as blank + (SCAN_DIV-1) clocks of one digit, in 0,1,2,3 order.
    int         mon_run  = 0;
    logic [3:0] mon_last = 4'b0111;
    always @(negedge clk) begin
        if (reset) begin
            mon_run  = 0;
            mon_last = 4'b0111;
        end else if (an == 4'b1111) begin
            if (mon_run != 0) begin
                check_int("slot_length", mon_run, SCAN_DIV - 1);
                mon_run = 0;
            end
        end else begin
            if (mon_run == 0) begin
                check4("digit_order", an, {mon_last[2:0], mon_last[3]});
                mon_last = an;
            end else begin
                check4("digit_hold", an, mon_last);
            end
            mon_run++;
        end
    end

    task automatic wait_an(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture_frame(output logic [6:0] g3, output logic [6:0] g2,
                                 output logic [6:0] g1, output logic [6:0] g0);
        bit ok1, ok2;
        g3 = 'x; g2 = 'x; g1 = 'x; g0 = 'x;
        wait_an(4'b1111, ok1);
        wait_an(4'b1110, ok2);
        if (!(ok1 && ok2)) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_sync: got an=%b, required a frame start within 100 clocks", an);
            return;
        end
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            case (an)
                4'b1110: g0 = seg_display;
                4'b1101: g1 = seg_display;
                4'b1011: g2 = seg_display;
                4'b0111: g3 = seg_display;
                default: ;
            endcase
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] dout, input logic [1:0] dout2, input logic [3:0] lvl);
        display_out  = dout;
        display_out2 = dout2;
        nivel        = lvl;
    endtask

    task automatic check_output(input string name, input logic [6:0] g3, input logic [6:0] g2,
                                input logic [6:0] g1, input logic [6:0] g0,
                                input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        check7({name, "_d3"}, g3, e3);
        check7({name, "_d2"}, g2, e2);
        check7({name, "_d1"}, g1, e1);
        check7({name, "_d0"}, g0, e0);
    endtask

    // Blink half-period is 4 frames, so any 8 consecutive frames hold exactly 4 blanked ones.
    task automatic blink_test(input string name, input logic [3:0] lvl, input logic [1:0] dout2,
                              input bit expect_blink, input logic [6:0] face, input logic [6:0] units);
        logic [6:0] g3, g2, g1, g0;
        int nblank;
        apply_stimulus(4'b0000, dout2, lvl);
        capture_frame(g3, g2, g1, g0);
        capture_frame(g3, g2, g1, g0);
        nblank = 0;
        for (int f = 0; f < 8; f++) begin
            capture_frame(g3, g2, g1, g0);
            check7({name, "_d3"}, g3, L_S);
            check7({name, "_d2"}, g2, face);
            check7({name, "_d1"}, g1, BLANK);
            if (g0 == BLANK) nblank++;
            else check7({name, "_d0"}, g0, units);
        end
        check_int({name, "_blank_frames"}, nblank, expect_blink ? 4 : 0);
    endtask

    initial begin
        logic [6:0] g3, g2, g1, g0;
        bit ok;

        vecs[0]  = '{4'b0101, 2'b00, 4'd7,  L_E, F_U, BLANK, G7};
        vecs[1]  = '{4'b0011, 2'b00, 4'd10, L_D, F_N, G1,    G0};
        vecs[2]  = '{4'b1000, 2'b00, 4'd13, L_S, DASH, DASH, DASH};
        vecs[3]  = '{4'b1100, 2'b01, 4'd1,  L_S, F_Z, BLANK, G1};
        vecs[4]  = '{4'b0110, 2'b10, 4'd9,  L_H, F_U, BLANK, G9};
        vecs[5]  = '{4'b1101, 2'b11, 4'd15, L_E, DASH, DASH, DASH};
        vecs[6]  = '{4'b0100, 2'b00, 4'd3,  L_S, F_U, BLANK, G3};
        vecs[7]  = '{4'b0001, 2'b00, 4'd8,  L_E, F_N, BLANK, G8};
        vecs[8]  = '{4'b0010, 2'b00, 4'd4,  L_H, F_N, BLANK, G4};
        vecs[9]  = '{4'b0000, 2'b00, 4'd5,  L_S, F_N, BLANK, G5};
        vecs[10] = '{4'b0111, 2'b01, 4'd6,  L_D, F_Z, BLANK, G6};
        vecs[11] = '{4'b0011, 2'b00, 4'd11, L_D, F_N, DASH,  DASH};

        reset = 1'b1;
        apply_stimulus(4'b0101, 2'b00, 4'd7);
        #12;
        check4("reset_an", an, 4'b1111);
        check7("reset_seg", seg_display, BLANK);
        @(negedge clk);
        reset = 1'b0;

        // The first frame shows reset values even though new inputs are already present.
        capture_frame(g3, g2, g1, g0);
        check_output("first_frame", g3, g2, g1, g0, L_S, DASH, BLANK, G0);
        capture_frame(g3, g2, g1, g0);
        check_output("latched_frame", g3, g2, g1, g0, L_E, F_U, BLANK, G7);

        wait_an(4'b1101, ok);
        check_int("midframe_sync", int'(ok), 1);
        apply_stimulus(4'b0011, 2'b00, 4'd10);
        wait_an(4'b0111, ok);
        check_int("midframe_sync2", int'(ok), 1);
        check7("midframe_hold", seg_display, L_E);
        capture_frame(g3, g2, g1, g0);
        check_output("midframe_next", g3, g2, g1, g0, L_D, F_N, G1, G0);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].dout, vecs[i].dout2, vecs[i].lvl);
            capture_frame(g3, g2, g1, g0);
            capture_frame(g3, g2, g1, g0);
            capture_frame(g3, g2, g1, g0);
            check_output($sformatf("vec%0d", i), g3, g2, g1, g0,
                         vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0);
        end

        blink_test("blink_lvl0",  4'd0, 2'b00, 1'b1, F_N, G0);
        blink_test("blink_lvl1",  4'd1, 2'b00, 1'b1, F_N, G1);
        blink_test("blink_lvl2",  4'd2, 2'b00, 1'b1, F_N, G2);
        blink_test("steady_lvl3", 4'd3, 2'b00, 1'b0, F_N, G3);
        blink_test("sleep_lvl1",  4'd1, 2'b01, 1'b0, F_Z, G1);

        // Reset in the middle of a lit slot must blank at once and restart at digit 0.
        wait_an(4'b1011, ok);
        check_int("midreset_sync", int'(ok), 1);
        #2;
        reset = 1'b1;
        #1;
        check4("midreset_an", an, 4'b1111);
        check7("midreset_seg", seg_display, BLANK);
        apply_stimulus(4'b0110, 2'b00, 4'd9);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        capture_frame(g3, g2, g1, g0);
        check_output("after_reset", g3, g2, g1, g0, L_S, DASH, BLANK, G0);
        capture_frame(g3, g2, g1, g0);
        check_output("after_reset_latch", g3, g2, g1, g0, L_H, F_U, BLANK, G9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
